// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and parameter legality check for the digit-serial adder
package adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic legal_cfg(input int w, input int d);
        return (d >= 1) && (d <= w) && (w % d == 0);
    endfunction

endpackage

// File: rtl/adder_digit.sv
// adder_digit: DIGIT-wide combinational ripple chain of full_adder cells
module adder_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_top
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a (a[i]),
            .b (b[i]),
            .ci(w_c[i]),
            .s (s[i]),
            .co(w_c[i+1])
        );
    end

    assign co    = w_c[DIGIT];
    assign c_top = w_c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full-adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/subtract, DIGIT bits per clock, LSB digit first, valid/ready on both sides
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (!legal_cfg(WIDTH, DIGIT)) begin : g_bad_cfg
        $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_k;
    logic             r_c;
    logic             r_cout;
    logic             r_ovf;
    logic [DIGIT-1:0] w_a;
    logic [DIGIT-1:0] w_b;
    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic             w_ctop;
    logic             w_last;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;
    assign w_last    = (r_k == LAST);

    // Select the current digit of both captured operands
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_k == CW'(i)) begin
                w_a = r_a[i*DIGIT +: DIGIT];
                w_b = r_b[i*DIGIT +: DIGIT];
            end
        end
    end

    adder_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (w_a),
        .b    (w_b),
        .ci   (r_c),
        .s    (w_s),
        .co   (w_co),
        .c_top(w_ctop)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state: accept in IDLE, run NDIG digits, hold result until consumed
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = in_valid  ? RUN  : IDLE;
            RUN:     w_next = w_last    ? DONE : RUN;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture (subtract folds into add of ~y with inverted carry seed) and per-digit accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_k    <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_a <= x;
            r_b <= sub ? ~y : y;
            r_c <= sub ? ~c_in : c_in;
            r_k <= '0;
        end else if (r_state == RUN) begin
            for (int i = 0; i < NDIG; i++) begin
                if (r_k == CW'(i)) r_sum[i*DIGIT +: DIGIT] <= w_s;
            end
            r_c <= w_co;
            r_k <= r_k + CW'(1);
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= w_ctop ^ w_co;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed vectors, handshake corner cases and DIGIT sweep for digit_serial_adder
module tb_digit_serial_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  c_out;
    logic [2:0]  ovf;
    logic [15:0] x;
    logic [15:0] y;
    logic        c_in;
    logic        sub;
    logic [15:0] sum [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x(x), .y(y), .c_in(c_in), .sub(sub), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum[0]), .c_out(c_out[0]), .ovf(ovf[0])
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x(x), .y(y), .c_in(c_in), .sub(sub), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum[1]), .c_out(c_out[1]), .ovf(ovf[1])
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .x(x), .y(y), .c_in(c_in), .sub(sub), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .sum(sum[2]), .c_out(c_out[2]), .ovf(ovf[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? 4 : ((u == 1) ? 1 : 16);
    endfunction

    // Reference: signed overflow from operand/result sign bits, independent of carry chain
    function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic ci, input logic sb);
        logic [15:0] bb;
        logic        cc;
        logic [16:0] t;
        bb = sb ? ~b : b;
        cc = sb ? ~ci : ci;
        t  = {1'b0, a} + {1'b0, bb} + {16'd0, cc};
        return {(a[15] == bb[15]) && (t[15] != a[15]), t[16], t[15:0]};
    endfunction

    task automatic run_op(input int u, input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb, input logic [15:0] es,
                          input logic ec, input logic eo);
        int lat;
        chk({tag, " ready"}, 32'(in_ready[u]), 32'd1);
        x = a;
        y = b;
        c_in = ci;
        sub = sb;
        in_valid[u] = 1'b1;
        tick();
        in_valid[u] = 1'b0;
        lat = 0;
        while (!out_valid[u] && lat < 64) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(lat_of(u)));
        chk({tag, " sum"}, 32'(sum[u]), 32'(es));
        chk({tag, " c_out"}, 32'(c_out[u]), 32'(ec));
        chk({tag, " ovf"}, 32'(ovf[u]), 32'(eo));
        out_ready[u] = 1'b1;
        tick();
        out_ready[u] = 1'b0;
        chk({tag, " idle"}, {30'd0, in_ready[u], out_valid[u]}, 32'b10);
    endtask

    initial begin
        vec_t        vecs [9];
        logic [17:0] r;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[8] = '{16'h1234, 16'h0234, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        x         = 16'hA5A5;
        y         = 16'h5A5A;
        c_in      = 1'b1;
        sub       = 1'b0;
        repeat (2) tick();
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("reset flags u%0d", u), {28'd0, in_ready[u], out_valid[u], c_out[u], ovf[u]}, 32'b1000);
            chk($sformatf("reset sum u%0d", u), 32'(sum[u]), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_op(0, $sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb,
                   vecs[i].s, vecs[i].c, vecs[i].o);
        end

        // Backpressure: result held while out_ready low and inputs wiggle
        x = 16'h00F0;
        y = 16'h000F;
        c_in = 1'b0;
        sub = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (4) tick();
        chk("bp done", 32'(out_valid[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid[0] = ~in_valid[0];
            x = x + 16'h1111;
            y = ~y;
            sub = ~sub;
            tick();
            chk($sformatf("bp sum %0d", i), 32'(sum[0]), 32'h00FF);
            chk($sformatf("bp flags %0d", i), {28'd0, in_ready[0], out_valid[0], c_out[0], ovf[0]}, 32'b0100);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        chk("bp release", {30'd0, in_ready[0], out_valid[0]}, 32'b10);
        chk("bp no accept", 32'(sum[0]), 32'h00FF);

        // Reset in the middle of RUN
        x = 16'h1234;
        y = 16'h1111;
        c_in = 1'b0;
        sub = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (2) tick();
        chk("partial sum", 32'(sum[0]), 32'h0045);
        rst_n = 1'b0;
        #1;
        chk("mid reset flags", {30'd0, in_ready[0], out_valid[0]}, 32'b10);
        chk("mid reset sum", 32'(sum[0]), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(0, "post reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // DIGIT = WIDTH and DIGIT = 1 sweeps against the reference model
        for (int u = 1; u < 3; u++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
                r  = ref_model(ra, rb, rc, rs);
                run_op(u, $sformatf("rnd u%0d n%0d", u, n), ra, rb, rc, rs, r[15:0], r[16], r[17]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
